delay_tap_reader: RTL and testbench
===================================

DELAY_TAP_READER -- requirements
Module: delay_tap_reader

Interface
REQ-001 clk  input  1  system clock; all state updates on rising edge.
REQ-002 rst  input  1  asynchronous, active-high reset.
REQ-003 shift_data_state  input  1  high for the cycle in which the tap chain shifts; taps carry new values from the next cycle.
REQ-004 taps  input  957  33 taps x 29 bits, signed two's complement; tap k occupies bits [29k+28:29k]; tap 0 is the newest sample.
REQ-005 dly_wr  input  1  delay write strobe.
REQ-006 dly_ch  input  2  channel written by dly_wr.
REQ-007 dly_val  input  6  requested delay in samples.
REQ-008 clr_ovf  input  1  clears the overrun flag.
REQ-009 out_data  output  29  selected tap sample, registered.
REQ-010 out_ch  output  2  channel of out_data.
REQ-011 out_valid  output  1  out_data/out_ch valid this cycle.
REQ-012 busy  output  1  high while the FSM is in any RDk state.
REQ-013 overrun  output  1  sticky flag: shift arrived too early.

Function
REQ-014 FSM states are IDLE, RD0, RD1, RD2 and RD3; RDk serves channel k.
REQ-015 Transitions: IDLE->RD0 on shift_data_state; RD0->RD1->RD2->RD3 unconditionally; RD3->RD0 if shift_data_state else IDLE.
REQ-016 In RDk, the block registers tap[act_dly[k]] into out_data and k into out_ch, and out_valid is high the following cycle only.
REQ-017 Latency: for a shift in cycle N, channel 0..3 results are valid in cycles N+2, N+3, N+4, N+5, in channel order.
REQ-018 Each channel has two 6-bit delay registers: staging (stg_dly) and active (act_dly).
REQ-019 dly_wr writes stg_dly[dly_ch] = min(dly_val, 32) on the clock edge; values 33..63 clamp to 32.
REQ-020 On the edge that enters RD0, act_dly[0..3] load from stg_dly; a dly_wr in that same cycle is included (write-through).
REQ-021 act_dly is stable for the whole frame; writes during RD0..RD3 take effect at the next frame.
REQ-022 A shift_data_state in RD0, RD1 or RD2 is ignored (no restart, frame continues) and sets overrun.
REQ-023 A shift_data_state in RD3 is legal and starts the next frame back-to-back, giving a minimum shift spacing of 4 cycles.
REQ-024 clr_ovf clears overrun; if clr_ovf and a set condition coincide, the set wins.
REQ-025 busy = 1 in RD0..RD3, otherwise 0.

Reset
REQ-026 rst asserted forces the FSM to IDLE and sets out_data=0, out_ch=0, out_valid=0, busy=0, overrun=0, stg_dly=0 and act_dly=0 immediately, independent of clk.
REQ-027 rst asserted mid-frame abandons the frame; no further out_valid is produced for it.
REQ-028 After rst deasserts, the first shift_data_state starts a normal frame.

Configuration
REQ-029 Macro DLY_SUM_EN, when defined, adds output sum_data (31 bits, signed) and output sum_valid (1 bit).
REQ-030 sum_data is the sign-extended sum of the four channel samples of one frame; sum_valid pulses one cycle, in cycle N+6 after a shift in cycle N; both reset to 0.
REQ-031 When DLY_SUM_EN is not defined, neither the ports nor the accumulator exist, and all other behaviour is unchanged.

Verification
REQ-032 After reset, load taps with tap k = k; write delays ch0..3 = 0, 5, 17, 32; pulse shift once -> out_valid in cycles N+2..N+5 with data 0, 5, 17, 32 and out_ch 0..3.
REQ-033 Write dly_val=45 to ch1 -> the next frame selects tap 32 for ch1.
REQ-034 Write ch2 = 3 during RD1 -> current frame ch2 keeps the old delay; the next frame uses 3.
REQ-035 Shifts 2 cycles apart -> second shift ignored, overrun=1, only 4 out_valid pulses; clr_ovf -> overrun=0. Shifts 4 cycles apart -> 8 contiguous out_valid pulses, overrun stays 0.
REQ-036 Assert rst in RD1 -> all outputs 0 at once, no further out_valid, and the next shift after release produces a normal frame.
REQ-037 With DLY_SUM_EN defined and selected samples -2^28, -2^28, -2^28, -2^28 -> sum_data = -2^30 in cycle N+6, no overflow.

Source files
------------

// File: rtl/delay_tap_reader.sv
// delay_tap_reader: once per frame, reads one delayed tap per channel (4 channels)
// from a 33-tap x 29-bit sample chain and presents the samples one per cycle.
// Optional feature: define DLY_SUM_EN to add a per-frame four-channel sum
// output (sum_data_o / sum_valid_o).
module delay_tap_reader (
   input  logic         clk,
   input  logic         rst,
   input  logic         shift_data_state_i,
   input  logic [956:0] taps_i,
   input  logic         dly_wr_i,
   input  logic [1:0]   dly_ch_i,
   input  logic [5:0]   dly_val_i,
   input  logic         clr_ovf_i,
   output logic [28:0]  out_data_o,
   output logic [1:0]   out_ch_o,
   output logic         out_valid_o,
   output logic         busy_o,
   output logic         overrun_o
`ifdef DLY_SUM_EN
   ,
   output logic [30:0]  sum_data_o,
   output logic         sum_valid_o
`endif
);

   localparam int unsigned NumTaps = 33;
   localparam int unsigned TapW    = 29;
   localparam int unsigned NumCh   = 4;
   localparam logic [5:0]  MaxDly  = 6'd32;

   typedef enum logic [2:0] {StIdle, StRd0, StRd1, StRd2, StRd3} state_e;

   state_e      state_q, state_d;
   logic [5:0]  stg_dly_q [NumCh];
   logic [5:0]  stg_dly_d [NumCh];
   logic [5:0]  act_dly_q [NumCh];
   logic [5:0]  act_dly_d [NumCh];
   logic [28:0] out_data_q, out_data_d;
   logic [1:0]  out_ch_q, out_ch_d;
   logic        out_valid_q, out_valid_d;
   logic        overrun_q, overrun_d;

   logic        load_act;
   logic        ovf_set;
   logic        rd_en;
   logic [1:0]  rd_ch;
   logic [5:0]  wr_val;
   logic [5:0]  sel_dly;
   logic [28:0] sel_tap;
   logic [28:0] tap_arr [NumTaps];

   // Unpack the flat tap bus; tap 0 is the newest sample.
   always_comb begin
      for (int i = 0; i < NumTaps; i++) begin
         tap_arr[i] = taps_i[i*TapW +: TapW];
      end
   end

   // Delay requests beyond the last tap clamp to the oldest tap.
   always_comb begin
      wr_val = (dly_val_i > MaxDly) ? MaxDly : dly_val_i;
   end

   // Staging delay registers: written at any time by the delay strobe.
   always_comb begin
      for (int i = 0; i < NumCh; i++) begin
         stg_dly_d[i] = stg_dly_q[i];
      end
      if (dly_wr_i) begin
         stg_dly_d[dly_ch_i] = wr_val;
      end
   end

   // Frame sequencer: RDk reads channel k; only RD3 may chain into a new frame.
   always_comb begin
      state_d  = state_q;
      load_act = 1'b0;
      ovf_set  = 1'b0;
      rd_en    = 1'b0;
      rd_ch    = 2'd0;
      unique case (state_q)
         StIdle: begin
            if (shift_data_state_i) begin
               state_d  = StRd0;
               load_act = 1'b1;
            end
         end
         StRd0: begin
            rd_en   = 1'b1;
            rd_ch   = 2'd0;
            state_d = StRd1;
            ovf_set = shift_data_state_i;
         end
         StRd1: begin
            rd_en   = 1'b1;
            rd_ch   = 2'd1;
            state_d = StRd2;
            ovf_set = shift_data_state_i;
         end
         StRd2: begin
            rd_en   = 1'b1;
            rd_ch   = 2'd2;
            state_d = StRd3;
            ovf_set = shift_data_state_i;
         end
         StRd3: begin
            rd_en = 1'b1;
            rd_ch = 2'd3;
            if (shift_data_state_i) begin
               state_d  = StRd0;
               load_act = 1'b1;
            end else begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // Active delays freeze for the frame; loading from the next-state staging value
   // lets a write in the frame-start cycle take effect immediately.
   always_comb begin
      for (int i = 0; i < NumCh; i++) begin
         act_dly_d[i] = load_act ? stg_dly_d[i] : act_dly_q[i];
      end
   end

   // Tap mux for the channel being read this cycle.
   always_comb begin
      sel_dly = act_dly_q[rd_ch];
      sel_tap = tap_arr[sel_dly];
   end

   // Output register next-state and the sticky overrun flag (set beats clear).
   always_comb begin
      out_data_d  = out_data_q;
      out_ch_d    = out_ch_q;
      out_valid_d = rd_en;
      if (rd_en) begin
         out_data_d = sel_tap;
         out_ch_d   = rd_ch;
      end
      overrun_d = overrun_q;
      if (ovf_set) begin
         overrun_d = 1'b1;
      end else if (clr_ovf_i) begin
         overrun_d = 1'b0;
      end
   end

   // State and output registers with asynchronous reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= StIdle;
         out_data_q  <= '0;
         out_ch_q    <= '0;
         out_valid_q <= 1'b0;
         overrun_q   <= 1'b0;
         for (int i = 0; i < NumCh; i++) begin
            stg_dly_q[i] <= '0;
            act_dly_q[i] <= '0;
         end
      end else begin
         state_q     <= state_d;
         out_data_q  <= out_data_d;
         out_ch_q    <= out_ch_d;
         out_valid_q <= out_valid_d;
         overrun_q   <= overrun_d;
         for (int i = 0; i < NumCh; i++) begin
            stg_dly_q[i] <= stg_dly_d[i];
            act_dly_q[i] <= act_dly_d[i];
         end
      end
   end

   assign out_data_o  = out_data_q;
   assign out_ch_o    = out_ch_q;
   assign out_valid_o = out_valid_q;
   assign overrun_o   = overrun_q;
   assign busy_o      = (state_q != StIdle);

`ifdef DLY_SUM_EN
   logic [30:0] acc_q, acc_d;
   logic [30:0] sum_data_q, sum_data_d;
   logic        sum_valid_q, sum_valid_d;
   logic [30:0] sample_ext;

   // Accumulate the registered channel samples; channel 0 restarts the sum,
   // channel 3 completes it one cycle after the last sample is presented.
   always_comb begin
      sample_ext  = {{2{out_data_q[28]}}, out_data_q};
      acc_d       = acc_q;
      sum_data_d  = sum_data_q;
      sum_valid_d = 1'b0;
      if (out_valid_q) begin
         if (out_ch_q == 2'd0) begin
            acc_d = sample_ext;
         end else begin
            acc_d = acc_q + sample_ext;
         end
         if (out_ch_q == 2'd3) begin
            sum_data_d  = acc_q + sample_ext;
            sum_valid_d = 1'b1;
         end
      end
   end

   // Accumulator and sum output registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q       <= '0;
         sum_data_q  <= '0;
         sum_valid_q <= 1'b0;
      end else begin
         acc_q       <= acc_d;
         sum_data_q  <= sum_data_d;
         sum_valid_q <= sum_valid_d;
      end
   end

   assign sum_data_o  = sum_data_q;
   assign sum_valid_o = sum_valid_q;
`endif

endmodule

// File: tb/tb_delay_tap_reader.sv
// Bench for delay_tap_reader: directed scenarios with literal expectations plus
// randomized traffic checked every cycle against a frame-timing model.
`timescale 1ns/1ps
module tb_delay_tap_reader;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         shift_data_state_i = 1'b0;
   logic [956:0] taps_i = '0;
   logic         dly_wr_i = 1'b0;
   logic [1:0]   dly_ch_i = '0;
   logic [5:0]   dly_val_i = '0;
   logic         clr_ovf_i = 1'b0;
   logic [28:0]  out_data_o;
   logic [1:0]   out_ch_o;
   logic         out_valid_o;
   logic         busy_o;
   logic         overrun_o;
`ifdef DLY_SUM_EN
   logic [30:0]  sum_data_o;
   logic         sum_valid_o;
`endif

   delay_tap_reader dut (
      .clk                (clk),
      .rst                (rst),
      .shift_data_state_i (shift_data_state_i),
      .taps_i             (taps_i),
      .dly_wr_i           (dly_wr_i),
      .dly_ch_i           (dly_ch_i),
      .dly_val_i          (dly_val_i),
      .clr_ovf_i          (clr_ovf_i),
      .out_data_o         (out_data_o),
      .out_ch_o           (out_ch_o),
      .out_valid_o        (out_valid_o),
      .busy_o             (busy_o),
      .overrun_o          (overrun_o)
`ifdef DLY_SUM_EN
      ,
      .sum_data_o         (sum_data_o),
      .sum_valid_o        (sum_valid_o)
`endif
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // A frame accepted at cycle s presents channel k in cycle s+2+k using the tap
   // value seen in cycle s+1+k. A shift is accepted if at least 4 cycles have
   // passed since the last accepted shift; a closer shift only raises overrun.
   int          cyc = 0;
   int          last_acc = 0;
   bit          have_last = 1'b0;
   logic [5:0]  m_stg [4];
   logic [5:0]  m_act [4];
   logic [28:0] m_data = '0;
   logic [1:0]  m_ch = '0;
   logic        m_valid = 1'b0;
   logic        m_busy = 1'b0;
   logic        m_ovf = 1'b0;
   logic [30:0] m_acc = '0;
   logic [30:0] m_sum = '0;
   logic [30:0] m_sum_pend = '0;
   logic        m_sum_valid = 1'b0;
   logic        m_sv_pend = 1'b0;

   function automatic logic [28:0] tap_at(input logic [5:0] idx);
      logic [956:0] t;
      t = taps_i;
      return t[int'(idx)*29 +: 29];
   endfunction

   always @(posedge clk or posedge rst) begin
      int d;
      logic [5:0] wv;
      logic [28:0] smp;
      if (rst) begin
         have_last   = 1'b0;
         m_data      = '0;
         m_ch        = '0;
         m_valid     = 1'b0;
         m_busy      = 1'b0;
         m_ovf       = 1'b0;
         m_acc       = '0;
         m_sum       = '0;
         m_sum_pend  = '0;
         m_sum_valid = 1'b0;
         m_sv_pend   = 1'b0;
         for (int i = 0; i < 4; i++) begin
            m_stg[i] = '0;
            m_act[i] = '0;
         end
      end else begin
         d = have_last ? (cyc - last_acc) : 1000;
         m_sum_valid = m_sv_pend;
         if (m_sv_pend) m_sum = m_sum_pend;
         m_sv_pend = 1'b0;
         if (d >= 1 && d <= 4) begin
            smp     = tap_at(m_act[d-1]);
            m_valid = 1'b1;
            m_data  = smp;
            m_ch    = 2'(d - 1);
            if (d == 1) m_acc = {{2{smp[28]}}, smp};
            else        m_acc = m_acc + {{2{smp[28]}}, smp};
            if (d == 4) begin
               m_sv_pend  = 1'b1;
               m_sum_pend = m_acc;
            end
         end else begin
            m_valid = 1'b0;
         end
         wv = (dly_val_i > 6'd32) ? 6'd32 : dly_val_i;
         if (dly_wr_i) m_stg[dly_ch_i] = wv;
         if (shift_data_state_i) begin
            if (d >= 4) begin
               last_acc  = cyc;
               have_last = 1'b1;
               for (int i = 0; i < 4; i++) m_act[i] = m_stg[i];
            end else begin
               m_ovf = 1'b1;
            end
         end else if (clr_ovf_i) begin
            m_ovf = 1'b0;
         end
         if (shift_data_state_i && d < 4) m_ovf = 1'b1;
         else if (clr_ovf_i && !(shift_data_state_i && d < 4)) m_ovf = 1'b0;
         m_busy = have_last && ((cyc + 1 - last_acc) >= 1) && ((cyc + 1 - last_acc) <= 4);
      end
      cyc = cyc + 1;
   end

   // Per-cycle comparison, sampled mid-cycle after all edges have settled.
   always @(negedge clk) begin
      #1;
      check("valid", 64'(out_valid_o), 64'(m_valid));
      check("busy", 64'(busy_o), 64'(m_busy));
      check("overrun", 64'(overrun_o), 64'(m_ovf));
      if (m_valid) begin
         check("data", 64'(out_data_o), 64'(m_data));
         check("ch", 64'(out_ch_o), 64'(m_ch));
      end
`ifdef DLY_SUM_EN
      check("sum_valid", 64'(sum_valid_o), 64'(m_sum_valid));
      if (m_sum_valid) check("sum_data", 64'(sum_data_o), 64'(m_sum));
`endif
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(negedge clk);
   endtask

   task automatic wr_dly(input logic [1:0] ch, input logic [5:0] val);
      dly_wr_i  = 1'b1;
      dly_ch_i  = ch;
      dly_val_i = val;
      tick();
      dly_wr_i  = 1'b0;
   endtask

   task automatic taps_ramp();
      logic [956:0] t;
      for (int i = 0; i < 33; i++) t[i*29 +: 29] = 29'(i);
      taps_i = t;
   endtask

   int lit[4] = '{0, 5, 17, 32};
   int vcount;
   int run;
   int maxrun;
   logic [959:0] rnd;

   initial begin
      tick();
      tick();
      check("reset_data", 64'(out_data_o), 64'd0);
      check("reset_valid_busy_ovf", {61'd0, out_valid_o, busy_o, overrun_o}, 64'd0);
      rst = 1'b0;
      tick();

      // Ramp taps, delays 0/5/17/32, one frame.
      taps_ramp();
      wr_dly(2'd0, 6'd0);
      wr_dly(2'd1, 6'd5);
      wr_dly(2'd2, 6'd17);
      wr_dly(2'd3, 6'd32);
      shift_data_state_i = 1'b1;
      tick();
      shift_data_state_i = 1'b0;
      check("lit_busy_rd0", 64'(busy_o), 64'd1);
      check("lit_valid_n1", 64'(out_valid_o), 64'd0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("lit_frame_valid", 64'(out_valid_o), 64'd1);
         check("lit_frame_data", 64'(out_data_o), 64'(lit[k]));
         check("lit_frame_ch", 64'(out_ch_o), 64'(k));
      end
      tick();
      check("lit_after_frame", {62'd0, out_valid_o, busy_o}, 64'd0);

      // Clamp: 45 on ch1 selects tap 32.
      wr_dly(2'd1, 6'd45);
      shift_data_state_i = 1'b1;
      tick();
      shift_data_state_i = 1'b0;
      tick();
      tick();
      check("lit_clamp_data", 64'(out_data_o), 64'd32);
      repeat (3) tick();

      // Write ch2 during RD1: current frame keeps 17, next frame uses 3.
      shift_data_state_i = 1'b1;
      tick();
      shift_data_state_i = 1'b0;
      tick();
      dly_wr_i = 1'b1; dly_ch_i = 2'd2; dly_val_i = 6'd3;
      tick();
      dly_wr_i = 1'b0;
      tick();
      check("lit_old_dly", 64'(out_data_o), 64'd17);
      repeat (3) tick();
      shift_data_state_i = 1'b1;
      tick();
      shift_data_state_i = 1'b0;
      repeat (3) tick();
      check("lit_new_dly", 64'(out_data_o), 64'd3);
      repeat (3) tick();

      // Shifts 2 apart: overrun, 4 pulses only.
      vcount = 0;
      for (int i = 0; i < 11; i++) begin
         shift_data_state_i = (i == 0 || i == 2);
         if (out_valid_o) vcount++;
         tick();
      end
      shift_data_state_i = 1'b0;
      check("lit_ovr_pulses", 64'(vcount), 64'd4);
      check("lit_ovr_set", 64'(overrun_o), 64'd1);
      clr_ovf_i = 1'b1;
      tick();
      clr_ovf_i = 1'b0;
      check("lit_ovr_clr", 64'(overrun_o), 64'd0);

      // Shifts 4 apart: 8 contiguous pulses, no overrun.
      vcount = 0; run = 0; maxrun = 0;
      for (int i = 0; i < 13; i++) begin
         shift_data_state_i = (i == 0 || i == 4);
         if (out_valid_o) begin
            vcount++; run++;
            if (run > maxrun) maxrun = run;
         end else begin
            run = 0;
         end
         tick();
      end
      shift_data_state_i = 1'b0;
      check("lit_b2b_pulses", 64'(vcount), 64'd8);
      check("lit_b2b_contig", 64'(maxrun), 64'd8);
      check("lit_b2b_no_ovr", 64'(overrun_o), 64'd0);

      // Reset in RD1 with overrun set and non-zero data pending.
      wr_dly(2'd0, 6'd7);
      shift_data_state_i = 1'b1;
      tick();
      tick();
      shift_data_state_i = 1'b0;
      check("lit_pre_rst_ovr", 64'(overrun_o), 64'd1);
      rst = 1'b1;
      #1;
      check("lit_rst_async", {out_data_o, out_ch_o, out_valid_o, busy_o, overrun_o}, 64'd0);
      tick();
      rst = 1'b0;
      vcount = 0;
      for (int i = 0; i < 6; i++) begin
         if (out_valid_o) vcount++;
         tick();
      end
      check("lit_rst_no_valid", 64'(vcount), 64'd0);
      taps_i[28:0] = 29'd99;
      shift_data_state_i = 1'b1;
      tick();
      shift_data_state_i = 1'b0;
      tick();
      check("lit_post_rst_data", 64'(out_data_o), 64'd99);
      repeat (3) tick();
      check("lit_post_rst_ch3", {61'd0, out_valid_o, out_ch_o}, 64'h7);
      tick();

`ifdef DLY_SUM_EN
      for (int i = 0; i < 33; i++) taps_i[i*29 +: 29] = 29'h1000_0000;
      shift_data_state_i = 1'b1;
      tick();
      shift_data_state_i = 1'b0;
      repeat (5) tick();
      check("lit_sum_valid", 64'(sum_valid_o), 64'd1);
      check("lit_sum_data", 64'(sum_data_o), 64'h4000_0000);
      tick();
`endif

      // Randomized traffic.
      for (int n = 0; n < 3000; n++) begin
         for (int w = 0; w < 30; w++) rnd[w*32 +: 32] = $urandom;
         taps_i             = rnd[956:0];
         shift_data_state_i = ($urandom_range(0, 3) == 0);
         dly_wr_i           = ($urandom_range(0, 2) == 0);
         dly_ch_i           = 2'($urandom_range(0, 3));
         dly_val_i          = 6'($urandom_range(0, 63));
         clr_ovf_i          = ($urandom_range(0, 7) == 0);
         rst                = ($urandom_range(0, 299) == 0);
         tick();
      end
      rst = 1'b0;
      shift_data_state_i = 1'b0;
      dly_wr_i = 1'b0;
      clr_ovf_i = 1'b0;
      repeat (8) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
